// File: rtl/pkg_en.sv
// Shared ElectronNest token types and widths used by the external-memory bridge.
package pkg_en;
  localparam int WIDTH_DATA   = 32;
  localparam int WIDTH_EXADDR = 12;

  typedef struct packed {
    logic                    v;
    logic                    a;
    logic                    r;
    logic                    c;
    logic [WIDTH_EXADDR-1:0] i;
    logic [WIDTH_DATA-1:0]   d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic t;
    logic v;
    logic c;
  } BTk_t;
endpackage

// File: rtl/en_extmem_bridge_if.sv
// Load/store token ports and SRAM port bundle between ElectronNest and the memory bridge.
interface en_extmem_bridge_if;
  import pkg_en::*;

  logic                    I_Boot_Start;
  logic                    O_Boot;
  logic                    I_Ld_Req;
  logic [WIDTH_EXADDR-1:0] I_Ld_Addr;
  FTk_t                    O_Ld_FTk;
  BTk_t                    I_Ld_BTk;
  logic                    I_St_Req;
  logic [WIDTH_EXADDR-1:0] I_St_Addr;
  FTk_t                    I_St_FTk;
  BTk_t                    O_St_BTk;
  logic                    O_Mem_Re;
  logic                    O_Mem_We;
  logic [WIDTH_EXADDR-1:0] O_Mem_Addr;
  logic [WIDTH_DATA-1:0]   O_Mem_WData;
  logic [WIDTH_DATA-1:0]   I_Mem_RData;

  // Bridge side.
  modport slave (
    input  I_Boot_Start, I_Ld_Req, I_Ld_Addr, I_Ld_BTk,
    input  I_St_Req, I_St_Addr, I_St_FTk, I_Mem_RData,
    output O_Boot, O_Ld_FTk, O_St_BTk,
    output O_Mem_Re, O_Mem_We, O_Mem_Addr, O_Mem_WData
  );

  // ElectronNest + SRAM side.
  modport master (
    output I_Boot_Start, I_Ld_Req, I_Ld_Addr, I_Ld_BTk,
    output I_St_Req, I_St_Addr, I_St_FTk, I_Mem_RData,
    input  O_Boot, O_Ld_FTk, O_St_BTk,
    input  O_Mem_Re, O_Mem_We, O_Mem_Addr, O_Mem_WData
  );
endinterface

// File: rtl/en_extmem_bridge.sv
// External-memory front end: streams boot tokens from SRAM, then serves fixed-latency
// loads and commits stores on a single-port write-first synchronous SRAM.
module en_extmem_bridge
  import pkg_en::*;
#(
  parameter int NUM_BOOT_PAD   = 3,
  parameter int NUM_BOOT_WORDS = 5,
  parameter int BOOT_BASE      = 0,
  parameter int EN_INDEX       = 0
) (
  input  logic              clock,
  input  logic              reset,
  en_extmem_bridge_if.slave bus
);

  localparam int BOOT_LEN = NUM_BOOT_PAD + NUM_BOOT_WORDS;
  localparam int CNT_W    = (BOOT_LEN > 1) ? $clog2(BOOT_LEN) : 1;

  typedef enum logic [1:0] {IDLE, BOOT, RUN} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    boot_last, boot_pad, boot_rd, boot_rd_idle;
  logic [WIDTH_EXADDR-1:0] boot_addr;
  logic                    ld_go, st_stall, st_ok;

  logic                    vld_p1, ld_vld_p1, tok_a_p1;
  logic [WIDTH_DATA-1:0]   tok_d_p1;
  logic [WIDTH_EXADDR-1:0] tok_i_p1, ld_idx_p1;

  assign boot_last = (cnt == CNT_W'(BOOT_LEN - 1));
  assign boot_pad  = (int'(cnt) < NUM_BOOT_PAD);
  // Word k is fetched while the counter shows k-1 so SRAM data lands as token k is registered.
  assign boot_rd      = (state == BOOT) && (int'(cnt) + 1 >= NUM_BOOT_PAD) && (int'(cnt) + 1 < BOOT_LEN);
  assign boot_rd_idle = (state == IDLE) && bus.I_Boot_Start && (NUM_BOOT_PAD == 0) && (NUM_BOOT_WORDS > 0);
  assign boot_addr    = boot_rd_idle ? WIDTH_EXADDR'(BOOT_BASE)
                                     : WIDTH_EXADDR'(BOOT_BASE + int'(cnt) + 1 - NUM_BOOT_PAD);

  assign ld_go    = (state == RUN) && bus.I_Ld_Req;
  assign st_stall = bus.I_St_Req && ((state != RUN) || (bus.I_Ld_Req && bus.I_St_FTk.v));
  assign st_ok    = (state == RUN) && bus.I_St_Req && bus.I_St_FTk.v && !st_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (bus.I_Boot_Start) begin
        state_nxt = BOOT;
        cnt_nxt   = '0;
      end
      BOOT: if (boot_last) begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0 -> p1: token register; load tokens take SRAM data directly in p1.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      tok_a_p1  <= 1'b0;
      ld_vld_p1 <= 1'b0;
      ld_idx_p1 <= '0;
      tok_d_p1  <= '0;
      tok_i_p1  <= '0;
    end else begin
      vld_p1    <= (state == BOOT);
      tok_a_p1  <= (state == BOOT) && (cnt == '0);
      ld_vld_p1 <= ld_go;
      if (ld_go) ld_idx_p1 <= (EN_INDEX != 0) ? bus.I_Ld_Addr : '0;
      if (state == BOOT) begin
        tok_d_p1 <= boot_pad ? '0 : bus.I_Mem_RData;
        tok_i_p1 <= '0;
      end else if (ld_vld_p1) begin
        tok_d_p1 <= bus.I_Mem_RData;
        tok_i_p1 <= ld_idx_p1;
      end
    end
  end

  always_comb begin
    bus.O_Boot     = (state == BOOT);
    bus.O_Ld_FTk   = '0;
    bus.O_Ld_FTk.v = vld_p1 || ld_vld_p1;
    bus.O_Ld_FTk.a = tok_a_p1;
    bus.O_Ld_FTk.d = ld_vld_p1 ? bus.I_Mem_RData : tok_d_p1;
    bus.O_Ld_FTk.i = ld_vld_p1 ? ld_idx_p1 : tok_i_p1;
    bus.O_St_BTk   = '0;
    bus.O_St_BTk.n = st_stall;
  end

  // Port priority: committed store, then load, then boot fetch.
  always_comb begin
    bus.O_Mem_Re    = 1'b0;
    bus.O_Mem_We    = 1'b0;
    bus.O_Mem_Addr  = '0;
    bus.O_Mem_WData = '0;
    if (st_ok) begin
      bus.O_Mem_We    = 1'b1;
      bus.O_Mem_Addr  = bus.I_St_Addr;
      bus.O_Mem_WData = bus.I_St_FTk.d;
    end else if (ld_go) begin
      bus.O_Mem_Re   = 1'b1;
      bus.O_Mem_Addr = bus.I_Ld_Addr;
    end else if (boot_rd || boot_rd_idle) begin
      bus.O_Mem_Re   = 1'b1;
      bus.O_Mem_Addr = boot_addr;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.I_Ld_BTk, bus.I_St_FTk.a, bus.I_St_FTk.r, bus.I_St_FTk.c, bus.I_St_FTk.i};

  a_ld_backpressure: assert property (@(posedge clock) disable iff (reset)
    ((state == RUN) && bus.I_Ld_BTk.n) |-> !bus.O_Ld_FTk.v);

endmodule

// File: tb/tb_en_extmem_bridge.sv
// Directed bench for en_extmem_bridge: spec-level token/memory model plus literal checkpoints.
module tb_en_extmem_bridge;
  import pkg_en::*;

  localparam int PAD   = 3;
  localparam int WORDS = 5;
  localparam int BASE  = 0;
  localparam int LEN   = PAD + WORDS;
  localparam int AW    = WIDTH_EXADDR;
  localparam int DW    = WIDTH_DATA;
  localparam int DEPTH = 1 << AW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  en_extmem_bridge_if bus();

  en_extmem_bridge #(
    .NUM_BOOT_PAD(PAD), .NUM_BOOT_WORDS(WORDS), .BOOT_BASE(BASE), .EN_INDEX(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_word(input int a);
    if (a <= 4) return DW'(32'hA0 + a);
    if (a >= 16 && a <= 19) return DW'(32'hB0 + a - 16);
    return DW'(32'h0001_0000 + a * 7);
  endfunction

  // Write-first synchronous SRAM, one-cycle read latency.
  logic [DW-1:0] sram [0:DEPTH-1];
  initial begin
    for (int a = 0; a < DEPTH; a++) sram[a] = init_word(a);
    bus.I_Mem_RData = '0;
    forever begin
      @(posedge clock);
      if (bus.O_Mem_We) sram[bus.O_Mem_Addr] <= bus.O_Mem_WData;
      if (bus.O_Mem_Re) bus.I_Mem_RData <= bus.O_Mem_We ? bus.O_Mem_WData : sram[bus.O_Mem_Addr];
    end
  end

  int            m_mode;   // 0 idle, 1 boot, 2 run
  int            m_k;
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  logic          e_v, e_a;
  logic [DW-1:0] e_d;
  logic [AW-1:0] e_i;
  logic [DW-1:0] dq [$];
  logic [AW-1:0] iq [$];
  int            boot_hi = 0;
  int            we_cnt  = 0;
  int            a_cnt   = 0;
  logic [DW-1:0] boot_exp [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Next-cycle token expectation from the inputs seen at this edge.
  task automatic model_step();
    if (reset) begin
      m_mode = 0; m_k = 0; e_v = 1'b0; e_a = 1'b0; e_d = '0; e_i = '0;
    end else begin
      case (m_mode)
        0: begin
          e_v = 1'b0; e_a = 1'b0;
          if (bus.I_Boot_Start) begin m_mode = 1; m_k = 0; end
        end
        1: begin
          e_v = 1'b1;
          e_a = (m_k == 0);
          e_i = '0;
          e_d = (m_k < PAD) ? '0 : ref_mem[BASE + m_k - PAD];
          m_k++;
          if (m_k == LEN) m_mode = 2;
        end
        default: begin
          e_a = 1'b0;
          e_v = bus.I_Ld_Req;
          if (bus.I_Ld_Req) begin
            e_d = ref_mem[bus.I_Ld_Addr];
            e_i = bus.I_Ld_Addr;
          end else if (bus.I_St_Req && bus.I_St_FTk.v) begin
            ref_mem[bus.I_St_Addr] = bus.I_St_FTk.d;
          end
        end
      endcase
    end
  endtask

  task automatic compare();
    logic run, ld, brd, e_we, e_re, e_n;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    run    = (m_mode == 2);
    ld     = run && bus.I_Ld_Req;
    brd    = (m_mode == 1) && (m_k + 1 >= PAD) && (m_k + 1 <= LEN - 1);
    e_we   = run && bus.I_St_Req && bus.I_St_FTk.v && !bus.I_Ld_Req;
    e_n    = bus.I_St_Req && (!run || (bus.I_Ld_Req && bus.I_St_FTk.v));
    e_re   = ld || brd;
    e_addr = e_we ? bus.I_St_Addr : ld ? bus.I_Ld_Addr : brd ? AW'(BASE + m_k + 1 - PAD) : '0;
    e_wd   = e_we ? bus.I_St_FTk.d : '0;
    check("boot", 64'(bus.O_Boot), 64'(m_mode == 1));
    check("ftk_v", 64'(bus.O_Ld_FTk.v), 64'(e_v));
    check("ftk_a", 64'(bus.O_Ld_FTk.a), 64'(e_a));
    check("ftk_rc", 64'({bus.O_Ld_FTk.r, bus.O_Ld_FTk.c}), 64'(0));
    check("ftk_d", 64'(bus.O_Ld_FTk.d), 64'(e_d));
    check("ftk_i", 64'(bus.O_Ld_FTk.i), 64'(e_i));
    check("st_btk", 64'(bus.O_St_BTk), 64'({e_n, 3'b000}));
    check("mem_re", 64'(bus.O_Mem_Re), 64'(e_re));
    check("mem_we", 64'(bus.O_Mem_We), 64'(e_we));
    check("mem_addr", 64'(bus.O_Mem_Addr), 64'(e_addr));
    check("mem_wdata", 64'(bus.O_Mem_WData), 64'(e_wd));
    if (bus.O_Ld_FTk.v) begin dq.push_back(bus.O_Ld_FTk.d); iq.push_back(bus.O_Ld_FTk.i); end
    if (bus.O_Boot) boot_hi++;
    if (bus.O_Mem_We) we_cnt++;
    if (bus.O_Ld_FTk.v && bus.O_Ld_FTk.a) a_cnt++;
  endtask

  task automatic half();
    @(negedge clock);
    compare();
  endtask

  task automatic fin();
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic cyc();
    half();
    fin();
  endtask

  task automatic boot_and_check(input string tag);
    int base, hb, ab;
    base = dq.size(); hb = boot_hi; ab = a_cnt;
    bus.I_Boot_Start = 1'b1;
    cyc();
    bus.I_Boot_Start = 1'b0;
    repeat (11) cyc();
    check({tag, "_ntok"}, 64'(dq.size() - base), 64'(8));
    for (int j = 0; j < 8; j++) check({tag, "_tok"}, 64'(dq[base + j]), 64'(boot_exp[j]));
    check({tag, "_boot_hi"}, 64'(boot_hi - hb), 64'(8));
    check({tag, "_a_once"}, 64'(a_cnt - ab), 64'(1));
  endtask

  initial begin
    int base, wb;
    boot_exp = '{32'h0, 32'h0, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
    m_mode = 0; m_k = 0; e_v = 1'b0; e_a = 1'b0; e_d = '0; e_i = '0;
    bus.I_Boot_Start = 1'b0;
    bus.I_Ld_Req     = 1'b0;
    bus.I_Ld_Addr    = '0;
    bus.I_Ld_BTk     = '0;
    bus.I_St_Req     = 1'b0;
    bus.I_St_Addr    = '0;
    bus.I_St_FTk     = '0;

    repeat (2) fin();
    reset = 1'b0;

    half();
    check("rst_boot", 64'(bus.O_Boot), 64'(0));
    check("rst_ftk", 64'(bus.O_Ld_FTk), 64'(0));
    check("rst_btk", 64'(bus.O_St_BTk), 64'(0));
    check("rst_mem", 64'({bus.O_Mem_Re, bus.O_Mem_We, bus.O_Mem_Addr}), 64'(0));
    fin();

    // Requests before boot are refused.
    bus.I_Ld_Req = 1'b1; bus.I_Ld_Addr = AW'(12'h010);
    bus.I_St_Req = 1'b1; bus.I_St_Addr = AW'(12'h022);
    bus.I_St_FTk.v = 1'b1; bus.I_St_FTk.d = 32'h77;
    half();
    check("idle_en", 64'({bus.O_Mem_Re, bus.O_Mem_We}), 64'(0));
    check("idle_v", 64'(bus.O_Ld_FTk.v), 64'(0));
    check("idle_n", 64'(bus.O_St_BTk.n), 64'(1));
    fin();
    cyc();
    bus.I_Ld_Req = 1'b0; bus.I_St_Req = 1'b0; bus.I_St_FTk = '0;
    cyc();

    boot_and_check("boot");

    // Load burst 0x10..0x13.
    base = dq.size();
    for (int j = 0; j < 4; j++) begin
      bus.I_Ld_Req = 1'b1; bus.I_Ld_Addr = AW'(16 + j);
      cyc();
    end
    bus.I_Ld_Req = 1'b0;
    cyc(); cyc();
    check("burst_ntok", 64'(dq.size() - base), 64'(4));
    for (int j = 0; j < 4; j++) begin
      check("burst_d", 64'(dq[base + j]), 64'(32'hB0 + j));
      check("burst_i", 64'(iq[base + j]), 64'(16 + j));
    end

    // Store then read-after-write.
    wb = we_cnt;
    bus.I_St_Req = 1'b1; bus.I_St_Addr = AW'(12'h020);
    bus.I_St_FTk.v = 1'b1; bus.I_St_FTk.d = 32'hDEAD;
    half();
    check("st_n", 64'(bus.O_St_BTk.n), 64'(0));
    check("st_we", 64'(bus.O_Mem_We), 64'(1));
    fin();
    bus.I_St_Req = 1'b0; bus.I_St_FTk = '0;
    base = dq.size();
    bus.I_Ld_Req = 1'b1; bus.I_Ld_Addr = AW'(12'h020);
    cyc();
    bus.I_Ld_Req = 1'b0;
    cyc(); cyc();
    check("st_we_pulses", 64'(we_cnt - wb), 64'(1));
    check("raw_d", 64'(dq[base]), 64'(32'hDEAD));

    // Load/store conflict: load wins, store retried.
    base = dq.size(); wb = we_cnt;
    bus.I_Ld_Req = 1'b1; bus.I_Ld_Addr = AW'(12'h030);
    bus.I_St_Req = 1'b1; bus.I_St_Addr = AW'(12'h031);
    bus.I_St_FTk.v = 1'b1; bus.I_St_FTk.d = 32'h55;
    half();
    check("cf_n", 64'(bus.O_St_BTk.n), 64'(1));
    check("cf_we", 64'(bus.O_Mem_We), 64'(0));
    check("cf_re", 64'(bus.O_Mem_Re), 64'(1));
    fin();
    bus.I_Ld_Req = 1'b0;
    half();
    check("retry_we", 64'(bus.O_Mem_We), 64'(1));
    check("retry_n", 64'(bus.O_St_BTk.n), 64'(0));
    check("retry_addr", 64'(bus.O_Mem_Addr), 64'(12'h031));
    fin();
    bus.I_St_Req = 1'b0; bus.I_St_FTk = '0;
    bus.I_Ld_Req = 1'b1; bus.I_Ld_Addr = AW'(12'h031);
    cyc();
    bus.I_Ld_Req = 1'b0;
    cyc(); cyc();
    check("cf_ld30", 64'(dq[base]), 64'(init_word(12'h030)));
    check("cf_ld31", 64'(dq[base + 1]), 64'(32'h55));
    check("cf_we_pulses", 64'(we_cnt - wb), 64'(1));

    // Reset in RUN, reboot, then reset at boot counter 4.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    bus.I_Boot_Start = 1'b1;
    cyc();
    bus.I_Boot_Start = 1'b0;
    repeat (4) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    half();
    check("mid_rst_boot", 64'(bus.O_Boot), 64'(0));
    check("mid_rst_ftk", 64'(bus.O_Ld_FTk), 64'(0));
    check("mid_rst_btk", 64'(bus.O_St_BTk), 64'(0));
    check("mid_rst_mem", 64'({bus.O_Mem_Re, bus.O_Mem_We, bus.O_Mem_Addr, bus.O_Mem_WData}), 64'(0));
    fin();
    cyc();

    boot_and_check("reboot");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/en_extmem_bridge.md
Name: en_extmem_bridge

Overview:
- Synthesizable external-memory front end sitting directly on the ElectronNest load/store ports. It replaces the behavioural memory and boot sequencer used in simulation.
- Issues the boot-word stream, then serves load requests with fixed latency and commits store tokens.
- Drives a single-port synchronous SRAM with 1-cycle read latency.
- Uses FTk_t, BTk_t, WIDTH_DATA and WIDTH_EXADDR from pkg_en.

Parameters:
- NUM_BOOT_PAD, 3: leading zero-data boot tokens.
- NUM_BOOT_WORDS, 5: boot tokens read from memory after the pad.
- BOOT_BASE, 0: memory address of the first boot word.
- EN_INDEX, 0: 1 = FTk.i carries the load address; 0 = FTk.i is driven '0.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- I_Boot_Start  in  1  one-cycle pulse that starts the boot sequence
- O_Boot  out  1  drives ElectronNest I_Boot
- I_Ld_Req  in  1  load request from ElectronNest
- I_Ld_Addr  in  WIDTH_EXADDR  load address
- O_Ld_FTk  out  FTk_t  load data token to ElectronNest
- I_Ld_BTk  in  BTk_t  load back-token (monitored only)
- I_St_Req  in  1  store request
- I_St_Addr  in  WIDTH_EXADDR  store address
- I_St_FTk  in  FTk_t  store data token
- O_St_BTk  out  BTk_t  store back-token; only .n is ever non-zero
- O_Mem_Re  out  1  SRAM read enable
- O_Mem_We  out  1  SRAM write enable
- O_Mem_Addr  out  WIDTH_EXADDR  SRAM address
- O_Mem_WData  out  WIDTH_DATA  SRAM write data
- I_Mem_RData  in  WIDTH_DATA  SRAM read data, valid 1 cycle after O_Mem_Re

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous, active-high.
- Reset values:
  - FSM = IDLE, boot counter = 0.
  - O_Boot=0, O_Ld_FTk='0, O_St_BTk='0.
  - O_Mem_Re=0, O_Mem_We=0, O_Mem_Addr='0, O_Mem_WData='0.
- Reset mid-boot or mid-run aborts all activity. The next cycle matches the reset values, and any in-flight read is discarded.
- FSM states: IDLE, BOOT, RUN.
- IDLE:
  - I_Boot_Start -> BOOT, counter=0, O_Boot=1.
  - Load and store requests are ignored; O_St_BTk.n=1.
- BOOT: counter runs 0..NUM_BOOT_PAD+NUM_BOOT_WORDS-1, i.e. 0..7 with default parameters.
  - O_Boot stays 1 throughout BOOT.
  - Each counter value k produces exactly one token on O_Ld_FTk, registered, in the cycle after k.
  - k < NUM_BOOT_PAD: v=1, d='0.
  - k >= NUM_BOOT_PAD: v=1, d=mem[BOOT_BASE+k-NUM_BOOT_PAD].
  - The SRAM read for word k is issued at cycle k-1 so that data aligns with the token.
  - a=1 only on the k=0 token. r=0, c=0, i='0 on all boot tokens.
  - After the last token, the FSM moves to RUN and O_Boot drops in the same cycle the last token is presented.
  - I_Boot_Start during BOOT or RUN is ignored.
- RUN, load path:
  - I_Ld_Req in cycle t drives O_Mem_Re=1 and O_Mem_Addr=I_Ld_Addr in cycle t.
  - Cycle t+1: O_Ld_FTk.v=1, d=I_Mem_RData, a=r=c=0, i=(EN_INDEX ? captured address : '0).
  - Back-to-back requests give one token per cycle.
  - With no request: v=0, and d/i hold their last value.
- RUN, store path:
  - A store commits when I_St_Req & I_St_FTk.v & ~O_St_BTk.n.
  - Commit drives O_Mem_We=1, O_Mem_Addr=I_St_Addr, O_Mem_WData=I_St_FTk.d, combinationally in the same cycle.
- Conflict (load and valid store in the same cycle):
  - The load wins.
  - O_St_BTk.n=1 combinationally that cycle, and no write occurs.
  - ElectronNest retries the store, which commits on the next conflict-free cycle.
- Read-after-write: a load to address X in the cycle after a store to X returns the new data, because the SRAM is write-first and the operations are in separate cycles.
- Address handling: no wrap-around is applied; addresses pass through unmodified.
- I_Ld_BTk is unused except as an assertion: v must not be raised while I_Ld_BTk.n=1 in RUN. This is flagged in simulation only.

Test Plan:
- Boot: SRAM[0..4]=0xA0..0xA4, pulse I_Boot_Start -> 8 consecutive v=1 tokens with d=0,0,0,A0,A1,A2,A3,A4; a=1 only on the first; O_Boot high for exactly 8 cycles.
- Load burst: I_Ld_Req for 4 cycles, addresses 0x10..0x13 holding 0xB0..0xB3 -> tokens B0..B3 on the next 4 cycles; with EN_INDEX=1, i=0x10..0x13.
- Store: I_St_Req with v=1, addr 0x20, d=0xDEAD, then load 0x20 the next cycle -> O_Mem_We pulse for one cycle; the load returns 0xDEAD; O_St_BTk.n=0.
- Conflict: load 0x30 and store 0x31=0x55 in the same cycle -> O_St_BTk.n=1, no write; store held for 1 more cycle commits; a later load of 0x31 returns 0x55.
- Reset mid-boot: assert reset at boot counter 4 -> all outputs zero next cycle; a later I_Boot_Start replays the full 8-token sequence from the first word.
- IDLE isolation: I_Ld_Req and I_St_Req asserted before boot -> no memory enables, O_Ld_FTk.v=0, O_St_BTk.n=1.
